// File: rtl/save_state_psram_arbiter_pkg.sv
// Shared types for the save-state PSRAM arbiter: FSM states, requester ids, beat geometry.
package save_state_pkg;

  localparam int unsigned SS_BEATS     = 4;
  localparam int unsigned PSRAM_ADDR_W = 22;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_W_ACK,
    ST_W_DONE,
    ST_R_ACK,
    ST_R_AVAIL,
    ST_BEAT_END
  } arb_state_t;

  typedef enum logic [1:0] {
    REQ_BW,
    REQ_BR,
    REQ_SS
  } req_id_t;

  // 16-bit lane of a 64-bit save-state word; lane 0 is bits [15:0].
  function automatic logic [15:0] ss_lane(input logic [63:0] d, input logic [1:0] idx);
    return d[{idx, 4'b0000} +: 16];
  endfunction

endpackage

// File: rtl/save_state_psram_arbiter_psram_req_latch.sv
// Latches a single-cycle request pulse with its payload until granted; flags dropped pulses.
module psram_req_latch #(
  parameter int unsigned DATA_W = 16
) (
  input  logic              clk_mem_85_9,
  input  logic              reset,
  input  logic              req,
  input  logic [DATA_W-1:0] din,
  input  logic              grant,
  output logic              pending,
  output logic [DATA_W-1:0] dout,
  output logic              overflow
);

  // A pulse coinciding with the grant becomes the next pending request.
  always_ff @(posedge clk_mem_85_9) begin
    if (reset) begin
      pending <= 1'b0;
      dout    <= '0;
    end else if (grant || !pending) begin
      pending <= req;
      if (req) dout <= din;
    end
  end

  assign overflow = req & pending & ~grant;

endmodule

// File: rtl/save_state_psram_arbiter.sv
// Fixed-priority arbiter sharing the 16-bit save-state PSRAM port between bridge and core.
module save_state_psram_arbiter
  import save_state_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter int unsigned ACK_STRETCH    = 4
) (
  input  logic                    clk_mem_85_9,
  input  logic                    reset,
  input  logic                    bw_req,
  input  logic [PSRAM_ADDR_W-1:0] bw_addr,
  input  logic [15:0]             bw_data,
  input  logic                    br_req,
  input  logic [PSRAM_ADDR_W-1:0] br_addr,
  output logic [15:0]             br_data,
  output logic                    br_valid,
  input  logic                    ss_req,
  input  logic                    ss_rnw,
  input  logic [19:0]             ss_addr,
  input  logic [63:0]             ss_din,
  output logic [63:0]             ss_dout,
  output logic                    ss_ack,
  output logic [PSRAM_ADDR_W-1:0] psram_addr,
  output logic [15:0]             psram_data_in,
  output logic                    psram_write_en,
  output logic                    psram_read_en,
  input  logic                    psram_write_ack,
  input  logic                    psram_read_ack,
  input  logic                    psram_read_avail,
  input  logic                    psram_busy,
  input  logic [15:0]             psram_data_out,
  output logic                    arb_busy,
  output logic                    timeout_err,
  output logic                    overflow_err
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam int unsigned ACK_W = $clog2(ACK_STRETCH + 1);
  localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(TIMEOUT_CYCLES);
  localparam logic [1:0]       LAST_BEAT = 2'(SS_BEATS - 1);

  logic        bw_pend, br_pend, ss_pend;
  logic        bw_ovf, br_ovf, ss_ovf;
  logic [37:0] bw_q;
  logic [PSRAM_ADDR_W-1:0] br_q;
  logic [84:0] ss_q;
  logic        gnt_bw, gnt_br, gnt_ss;

  req_id_t                 gnt_id;
  logic                    gnt_rnw;
  logic [PSRAM_ADDR_W-1:0] gnt_addr;
  logic [63:0]             gnt_wdata;

  arb_state_t  state;
  req_id_t     cur_id;
  logic        cur_rnw;
  logic [19:0] cur_base;
  logic [63:0] cur_wdata;
  logic [63:0] rbuf;
  logic [1:0]  beat, next_beat;
  logic [CNT_W-1:0] cnt;
  logic [ACK_W-1:0] ack_cnt;
  logic        wr_ack_q, avail_q, busy_q;
  logic        wr_rise, avail_rise, busy_fall, timed_out;

  psram_req_latch #(.DATA_W(38)) u_bw_latch (
    .clk_mem_85_9(clk_mem_85_9), .reset(reset), .req(bw_req), .din({bw_addr, bw_data}),
    .grant(gnt_bw), .pending(bw_pend), .dout(bw_q), .overflow(bw_ovf)
  );

  psram_req_latch #(.DATA_W(PSRAM_ADDR_W)) u_br_latch (
    .clk_mem_85_9(clk_mem_85_9), .reset(reset), .req(br_req), .din(br_addr),
    .grant(gnt_br), .pending(br_pend), .dout(br_q), .overflow(br_ovf)
  );

  psram_req_latch #(.DATA_W(85)) u_ss_latch (
    .clk_mem_85_9(clk_mem_85_9), .reset(reset), .req(ss_req), .din({ss_rnw, ss_addr, ss_din}),
    .grant(gnt_ss), .pending(ss_pend), .dout(ss_q), .overflow(ss_ovf)
  );

  // A PSRAM still busy from before reset blocks every grant until it settles.
  always_comb begin
    gnt_bw = 1'b0;
    gnt_br = 1'b0;
    gnt_ss = 1'b0;
    if (state == ST_IDLE && !psram_busy) begin
      gnt_bw = bw_pend;
      gnt_br = br_pend & ~bw_pend;
      gnt_ss = ss_pend & ~bw_pend & ~br_pend;
    end
  end

  always_comb begin
    gnt_id    = REQ_BW;
    gnt_rnw   = 1'b0;
    gnt_addr  = bw_q[37:16];
    gnt_wdata = {48'h0, bw_q[15:0]};
    if (gnt_br) begin
      gnt_id    = REQ_BR;
      gnt_rnw   = 1'b1;
      gnt_addr  = br_q;
      gnt_wdata = '0;
    end else if (gnt_ss) begin
      gnt_id    = REQ_SS;
      gnt_rnw   = ss_q[84];
      gnt_addr  = {ss_q[83:64], 2'b00};
      gnt_wdata = ss_q[63:0];
    end
  end

  assign wr_rise    = psram_write_ack & ~wr_ack_q;
  assign avail_rise = psram_read_avail & ~avail_q;
  assign busy_fall  = ~psram_busy & busy_q;
  assign timed_out  = (cnt == CNT_MAX);
  assign next_beat  = beat + 2'd1;
  assign arb_busy   = (state != ST_IDLE) | bw_pend | br_pend | ss_pend;

  always_ff @(posedge clk_mem_85_9) begin
    if (reset) begin
      state          <= ST_IDLE;
      cur_id         <= REQ_BW;
      cur_rnw        <= 1'b0;
      cur_base       <= '0;
      cur_wdata      <= '0;
      rbuf           <= '0;
      beat           <= '0;
      cnt            <= '0;
      ack_cnt        <= '0;
      wr_ack_q       <= 1'b0;
      avail_q        <= 1'b0;
      busy_q         <= 1'b0;
      psram_addr     <= '0;
      psram_data_in  <= '0;
      psram_write_en <= 1'b0;
      psram_read_en  <= 1'b0;
      br_data        <= '0;
      br_valid       <= 1'b0;
      ss_dout        <= '0;
      ss_ack         <= 1'b0;
      timeout_err    <= 1'b0;
      overflow_err   <= 1'b0;
    end else begin
      psram_write_en <= 1'b0;
      psram_read_en  <= 1'b0;
      br_valid       <= 1'b0;
      wr_ack_q       <= psram_write_ack;
      avail_q        <= psram_read_avail;
      busy_q         <= psram_busy;
      if (bw_ovf || br_ovf || ss_ovf) overflow_err <= 1'b1;

      if (ack_cnt != '0) ack_cnt <= ack_cnt - ACK_W'(1);
      else               ss_ack  <= 1'b0;

      case (state)
        ST_IDLE: begin
          if (gnt_bw || gnt_br || gnt_ss) begin
            cur_id         <= gnt_id;
            cur_rnw        <= gnt_rnw;
            cur_base       <= ss_q[83:64];
            cur_wdata      <= gnt_wdata;
            rbuf           <= '0;
            beat           <= '0;
            cnt            <= '0;
            psram_addr     <= gnt_addr;
            psram_data_in  <= gnt_wdata[15:0];
            psram_write_en <= ~gnt_rnw;
            psram_read_en  <= gnt_rnw;
            state          <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          cnt   <= CNT_W'(1);
          state <= cur_rnw ? ST_R_ACK : ST_W_ACK;
        end
        ST_W_ACK: begin
          if (wr_rise) begin
            cnt   <= cnt + CNT_W'(1);
            state <= ST_W_DONE;
          end else if (timed_out) begin
            timeout_err <= 1'b1;
            state       <= ST_BEAT_END;
          end else cnt <= cnt + CNT_W'(1);
        end
        ST_W_DONE: begin
          if (busy_fall) state <= ST_BEAT_END;
          else if (timed_out) begin
            timeout_err <= 1'b1;
            state       <= ST_BEAT_END;
          end else cnt <= cnt + CNT_W'(1);
        end
        ST_R_ACK: begin
          if (psram_read_ack) begin
            cnt   <= cnt + CNT_W'(1);
            state <= ST_R_AVAIL;
          end else if (timed_out) begin
            timeout_err                  <= 1'b1;
            rbuf[{beat, 4'b0000} +: 16] <= 16'h0000;
            state                        <= ST_BEAT_END;
          end else cnt <= cnt + CNT_W'(1);
        end
        ST_R_AVAIL: begin
          if (avail_rise) begin
            rbuf[{beat, 4'b0000} +: 16] <= psram_data_out;
            state                        <= ST_BEAT_END;
          end else if (timed_out) begin
            timeout_err                  <= 1'b1;
            rbuf[{beat, 4'b0000} +: 16] <= 16'h0000;
            state                        <= ST_BEAT_END;
          end else cnt <= cnt + CNT_W'(1);
        end
        ST_BEAT_END: begin
          cnt <= '0;
          if (cur_id == REQ_SS && beat != LAST_BEAT) begin
            beat           <= next_beat;
            psram_addr     <= {cur_base, next_beat};
            psram_data_in  <= ss_lane(cur_wdata, next_beat);
            psram_write_en <= ~cur_rnw;
            psram_read_en  <= cur_rnw;
            state          <= ST_ISSUE;
          end else begin
            state <= ST_IDLE;
            if (cur_id == REQ_BR) begin
              br_data  <= rbuf[15:0];
              br_valid <= 1'b1;
            end else if (cur_id == REQ_SS) begin
              if (cur_rnw) ss_dout <= rbuf;
              ss_ack  <= 1'b1;
              ack_cnt <= ACK_W'(ACK_STRETCH - 1);
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
